tt_capture: RTL
===============

Name: tt_capture

Overview:
- Sequential truth-table sweeper that sits directly upstream of a 7-input combinational classification function.
- Drives all 2^N_IN input minterms onto the function's inputs, samples its single-bit result each cycle, and assembles the full truth table.
- Presents the packed truth table plus its ones-count to the downstream classifier/logger over a valid/ready handshake.

Parameters:
- N_IN, 7, number of function inputs; minterm counter width.
- TT_W, 1<<N_IN (128), truth-table width; derived, not to be overridden.
- CNT_W, N_IN+1 (8), ones-count width (holds 0..TT_W).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- busy  output  1  high from accepted start until result handshake completes.
- x  output  N_IN  minterm driven to function under test; x[0] maps to x0.
- f  input  1  function result for current x (combinational return path).
- tt  output  TT_W  captured truth table; tt[i] = f when x == i.
- ones  output  CNT_W  number of set bits in tt.
- tt_valid  output  1  result valid; held until accepted.
- tt_ready  input  1  downstream accept.

Behaviour:
- Reset: state=IDLE; x=0, tt=0, ones=0, tt_valid=0, busy=0. Reset is asynchronous, so asserting it mid-sweep or mid-hold aborts immediately with no partial result.
- States: IDLE, SWEEP, HOLD (plus DRAIN when TT_CAPTURE_PIPE_EN is defined).
- IDLE:
  - start=1 clears tt and ones, sets x=0, moves to SWEEP, and asserts busy.
  - tt and ones keep the last result while in IDLE until the next start.
- SWEEP, per cycle:
  - Write tt[x] <= f.
  - Add f to ones.
  - Increment x.
  - When x==TT_W-1 is sampled, go to HOLD (non-pipelined). x wraps to 0 and is held at 0 afterwards.
- Latency: start accepted at edge 0; samples taken at edges 1..128; tt_valid=1 after edge 128.
- HOLD:
  - tt_valid=1; tt and ones stable.
  - tt_valid && tt_ready moves to IDLE at the next edge, clearing tt_valid and busy.
  - tt_ready may be held high permanently: a zero-stall result is valid for exactly one cycle.
- start is ignored while busy=1, including in the same cycle as the handshake. A new sweep needs start in IDLE.
- tt_ready is ignored when tt_valid=0.
- ones never overflows: max 128 fits in CNT_W=8.
- x changes only on clock edges, so the function path has one full cycle to settle.

Optional Feature:
- Macro: TT_CAPTURE_PIPE_EN.
- Defined:
  - f is registered once before use, together with a delayed copy of the minterm index.
  - After the last minterm the FSM enters DRAIN for one cycle to write the final sample, then goes to HOLD.
  - tt_valid asserts one cycle later than the non-pipelined case (after edge 129).
  - The captured contents are identical to the non-pipelined case.
- Undefined: f is sampled directly; there is no DRAIN state.

Decomposition:
- Shared package tt_pkg:
  - N_IN, TT_W and CNT_W constants.
  - State enum (IDLE, SWEEP, DRAIN, HOLD).
  - Truth-table typedef for TT_W-bit vectors, reused by downstream classifiers.
- One natural sub-module, tt_minterm_gen: minterm counter with enable and clear, plus a last-minterm flag.
- The FSM, capture register and ones accumulator stay in tt_capture.

Test Plan:
- Reset during SWEEP at x=40 -> outputs immediately at reset values, busy=0; the next start gives a clean full sweep.
- f = majority(x[0],x[1],x[2]), start pulse, tt_ready=1 -> tt=128'hE8E8_E8E8_E8E8_E8E8_E8E8_E8E8_E8E8_E8E8, ones=64, tt_valid one cycle at edge 128 (129 with PIPE_EN).
- f = x[6] -> tt=128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000, ones=64; x sequence checked 0..127 in order.
- f = 0, then f = 1 -> tt=0, ones=0; then tt=all-ones, ones=128 (no overflow).
- Backpressure: tt_ready=0 for 20 cycles after tt_valid -> tt, ones and tt_valid stable and busy=1; start pulses during the stall are ignored. Raising tt_ready returns to IDLE in one cycle.
- Back-to-back: start asserted in the cycle after the handshake -> second sweep starts, tt cleared, and the result matches the new function.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared constants and types for the truth-table capture path.
// Downstream classifiers reuse tt_t for the packed truth table.
package tt_pkg;

  localparam int unsigned N_IN  = 7;
  localparam int unsigned TT_W  = 1 << N_IN;
  localparam int unsigned CNT_W = N_IN + 1;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    HOLD
  } state_t;

  typedef logic [TT_W-1:0] tt_t;

endpackage

// File: rtl/tt_minterm_gen.sv
// Minterm counter for the truth-table sweep: clears to 0, increments when
// enabled, wraps after the last minterm, and flags the last minterm.
module tt_minterm_gen
  import tt_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            clr,
  output logic [N_IN-1:0] x,
  output logic            last
);

  // Minterm index register; natural wrap returns it to 0 after the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
    end else if (clr) begin
      x <= '0;
    end else if (en) begin
      x <= x + 1'b1;
    end
  end

  assign last = &x;

endmodule

// File: rtl/tt_capture.sv
// Truth-table sweeper: walks all minterms of a 7-input combinational
// function, captures its result into a packed table with a ones count, and
// hands the result downstream over valid/ready.
// Optional macro TT_CAPTURE_PIPE_EN registers f (and its minterm index)
// before capture and adds a one-cycle DRAIN state.
module tt_capture
  import tt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic [N_IN-1:0]  x,
  input  logic             f,
  output logic [TT_W-1:0]  tt,
  output logic [CNT_W-1:0] ones,
  output logic             tt_valid,
  input  logic             tt_ready
);

  state_t          state;
  logic            gen_en;
  logic            gen_clr;
  logic            last;
  logic            sample_v;
  logic            sample_f;
  logic [N_IN-1:0] sample_idx;

  assign gen_clr = (state == IDLE) && start;
  assign gen_en  = (state == SWEEP);

  tt_minterm_gen u_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (gen_en),
    .clr  (gen_clr),
    .x    (x),
    .last (last)
  );

`ifdef TT_CAPTURE_PIPE_EN
  logic            f_q;
  logic [N_IN-1:0] idx_q;
  logic            v_q;

  // Register f with the minterm it belongs to; capture happens one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q   <= 1'b0;
      idx_q <= '0;
      v_q   <= 1'b0;
    end else begin
      f_q   <= f;
      idx_q <= x;
      v_q   <= (state == SWEEP);
    end
  end

  assign sample_v   = v_q;
  assign sample_f   = f_q;
  assign sample_idx = idx_q;
`else
  assign sample_v   = (state == SWEEP);
  assign sample_f   = f;
  assign sample_idx = x;
`endif

  // Control FSM plus capture register and ones accumulator.
  // Samples never coincide with the IDLE clear, so the two writes to tt/ones
  // below are mutually exclusive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tt       <= '0;
      ones     <= '0;
      tt_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (sample_v) begin
        tt[sample_idx] <= sample_f;
        ones           <= ones + CNT_W'(sample_f);
      end
      case (state)
        IDLE: begin
          if (start) begin
            tt    <= '0;
            ones  <= '0;
            busy  <= 1'b1;
            state <= SWEEP;
          end
        end
        SWEEP: begin
          if (last) begin
`ifdef TT_CAPTURE_PIPE_EN
            state    <= DRAIN;
`else
            state    <= HOLD;
            tt_valid <= 1'b1;
`endif
          end
        end
        DRAIN: begin
          state    <= HOLD;
          tt_valid <= 1'b1;
        end
        HOLD: begin
          if (tt_ready) begin
            state    <= IDLE;
            tt_valid <= 1'b0;
            busy     <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
